// File: rtl/tempo_pkg.sv
// Shared widths, hold-FSM encoding and the saturating BPM step helper for the
// metronome tempo controller.
package tempo_pkg;

    localparam int BPM_W         = 8;
    localparam int BEATS_PER_BAR = 4;
    localparam int IDX_W         = $clog2(BEATS_PER_BAR);
    localparam int ACC_W         = 33;

    typedef enum logic [1:0] {
        HOLD_IDLE   = 2'd0,
        HOLD_DELAY  = 2'd1,
        HOLD_REPEAT = 2'd2
    } hold_state_t;

    function automatic logic [BPM_W-1:0] bpm_step(
        input logic [BPM_W-1:0] bpm,
        input logic             up,
        input logic [BPM_W-1:0] lo,
        input logic [BPM_W-1:0] hi
    );
        if (up)
            return (bpm >= hi) ? hi : bpm + 1'b1;
        else
            return (bpm <= lo) ? lo : bpm - 1'b1;
    endfunction

endpackage

// File: rtl/tempo_ctrl_beat_accum.sv
// Phase accumulator: adds bpm every running cycle and emits a beat each time the
// sum crosses THRESH, keeping the remainder so the long-run rate is exact.
module beat_accum
    import tempo_pkg::*;
#(
    parameter logic [ACC_W-1:0] THRESH = 33'd3_000_000_000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic [BPM_W-1:0] bpm,
    output logic             beat,
    output logic [IDX_W-1:0] idx
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic             pending;

    assign sum = acc + ACC_W'(bpm);

    // pending marks the cycle after a clear; if running, it becomes the downbeat
    // and the accumulator starts adding only from the following cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc     <= '0;
            pending <= 1'b0;
            beat    <= 1'b0;
            idx     <= '0;
        end else begin
            pending <= clear;
            beat    <= 1'b0;
            if (clear) begin
                acc <= '0;
                idx <= '0;
            end else if (enable) begin
                if (pending) begin
                    beat <= 1'b1;
                    idx  <= '0;
                end else if (sum >= THRESH) begin
                    acc  <= sum - THRESH;
                    beat <= 1'b1;
                    idx  <= idx + 1'b1;
                end else begin
                    acc <= sum;
                end
            end
        end
    end

endmodule

// File: rtl/tempo_ctrl.sv
// Metronome controller: button edge detection, up/down arbitration with hold
// auto-repeat, run/stop toggle; beat scheduling is delegated to beat_accum.
//   state       | meaning
//   HOLD_IDLE   | no button being tracked; waiting for a valid up/down press
//   HOLD_DELAY  | button held after its press, timing the initial repeat delay
//   HOLD_REPEAT | auto-repeat, one step every REPEAT_PERIOD cycles
module tempo_ctrl
    import tempo_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 50_000_000,
    parameter int unsigned BPM_MIN       = 30,
    parameter int unsigned BPM_MAX       = 240,
    parameter int unsigned BPM_DEFAULT   = 120,
    parameter int unsigned REPEAT_DELAY  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_btn_up,
    input  logic             i_btn_down,
    input  logic             i_btn_start,
    output logic [BPM_W-1:0] o_bpm,
    output logic             o_running,
    output logic             o_beat,
    output logic [IDX_W-1:0] o_beat_idx
);

    localparam logic [ACC_W-1:0] THRESH = ACC_W'(64'(CLK_HZ) * 64'd60);
    localparam logic [BPM_W-1:0] BPM_LO  = BPM_W'(BPM_MIN);
    localparam logic [BPM_W-1:0] BPM_HI  = BPM_W'(BPM_MAX);
    localparam logic [BPM_W-1:0] BPM_RST = BPM_W'(BPM_DEFAULT);
    localparam int CNT_W = $clog2((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) + 1;
    localparam logic [CNT_W-1:0] DLY_LOAD = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LOAD = CNT_W'(REPEAT_PERIOD - 1);

    hold_state_t      state;
    logic             dir;
    logic [CNT_W-1:0] cnt;
    logic             prev_up, prev_dn, prev_st;
    logic             press_up, press_dn, press_st;
    logic             valid_up, valid_dn;
    logic             dir_held, opp_high;

    assign press_up = i_btn_up & ~prev_up;
    assign press_dn = i_btn_down & ~prev_dn;
    assign press_st = i_btn_start & ~prev_st;
    assign valid_up = press_up & ~i_btn_down;
    assign valid_dn = press_dn & ~i_btn_up;
    assign dir_held = dir ? i_btn_up : i_btn_down;
    assign opp_high = dir ? i_btn_down : i_btn_up;

    // Resetting to 1 keeps a button held through reset from counting as a press.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev_up <= 1'b1;
            prev_dn <= 1'b1;
            prev_st <= 1'b1;
        end else begin
            prev_up <= i_btn_up;
            prev_dn <= i_btn_down;
            prev_st <= i_btn_start;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= HOLD_IDLE;
            dir   <= 1'b0;
            cnt   <= '0;
            o_bpm <= BPM_RST;
        end else if (valid_up || valid_dn) begin
            state <= HOLD_DELAY;
            dir   <= valid_up;
            cnt   <= DLY_LOAD;
            o_bpm <= bpm_step(o_bpm, valid_up, BPM_LO, BPM_HI);
        end else if (state != HOLD_IDLE && (!dir_held || opp_high)) begin
            state <= HOLD_IDLE;
        end else begin
            case (state)
                HOLD_DELAY: begin
                    if (cnt == '0) begin
                        state <= HOLD_REPEAT;
                        cnt   <= PER_LOAD;
                        o_bpm <= bpm_step(o_bpm, dir, BPM_LO, BPM_HI);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD_REPEAT: begin
                    if (cnt == '0) begin
                        cnt   <= PER_LOAD;
                        o_bpm <= bpm_step(o_bpm, dir, BPM_LO, BPM_HI);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_running <= 1'b0;
        else if (press_st)
            o_running <= ~o_running;
    end

    beat_accum #(
        .THRESH (THRESH)
    ) u_beat_accum (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .enable  (o_running),
        .clear   (press_st),
        .bpm     (o_bpm),
        .beat    (o_beat),
        .idx     (o_beat_idx)
    );

endmodule

// File: tb/tb_tempo_ctrl.sv
// Bench for tempo_ctrl with small clock/repeat constants; table vectors,
// hand sequences for hold/saturation/stop/reset, and a random run vs a model.
module tb_tempo_ctrl;

    localparam int CLK_HZ  = 10;
    localparam int THRESH  = CLK_HZ * 60;
    localparam int BPM_MIN = 30;
    localparam int BPM_MAX = 240;
    localparam int BPM_DEF = 120;
    localparam int RD      = 8;
    localparam int RP      = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_up = 1'b0, btn_dn = 1'b0, btn_st = 1'b0;
    logic [7:0] bpm;
    logic       running, beat;
    logic [1:0] beat_idx;

    int n_checks = 0;
    int n_fail   = 0;

    tempo_ctrl #(
        .CLK_HZ        (CLK_HZ),
        .BPM_MIN       (BPM_MIN),
        .BPM_MAX       (BPM_MAX),
        .BPM_DEFAULT   (BPM_DEF),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_btn_up    (btn_up),
        .i_btn_down  (btn_dn),
        .i_btn_start (btn_st),
        .o_bpm       (bpm),
        .o_running   (running),
        .o_beat      (beat),
        .o_beat_idx  (beat_idx)
    );

    initial forever #5 clk = ~clk;

    // Reference model: hold tracked as "cycles since press", beats as an
    // integer phase total.
    int m_bpm, m_idx, m_acc, m_hdir, m_t;
    bit m_run, m_beat, m_due, m_pu, m_pd, m_ps;

    task automatic model_reset();
        m_bpm = BPM_DEF; m_idx = 0; m_acc = 0; m_hdir = 0; m_t = 0;
        m_run = 0; m_beat = 0; m_due = 0; m_pu = 1; m_pd = 1; m_ps = 1;
    endtask

    function automatic int sat(int v);
        if (v < BPM_MIN) return BPM_MIN;
        if (v > BPM_MAX) return BPM_MAX;
        return v;
    endfunction

    task automatic model_step(bit up, bit dn, bit st);
        bit pu, pd, ps, held, opp;
        int old_bpm;
        pu = up && !m_pu; pd = dn && !m_pd; ps = st && !m_ps;
        m_pu = up; m_pd = dn; m_ps = st;
        old_bpm = m_bpm;
        m_beat = 0;
        if (ps) begin
            m_run = !m_run; m_acc = 0; m_idx = 0; m_due = m_run;
        end else if (m_run) begin
            if (m_due) begin
                m_beat = 1; m_idx = 0; m_due = 0;
            end else begin
                m_acc += old_bpm;
                if (m_acc >= THRESH) begin
                    m_acc -= THRESH; m_beat = 1; m_idx = (m_idx + 1) % 4;
                end
            end
        end
        if (pu && !dn) begin
            m_bpm = sat(m_bpm + 1); m_hdir = 1; m_t = 0;
        end else if (pd && !up) begin
            m_bpm = sat(m_bpm - 1); m_hdir = -1; m_t = 0;
        end else if (m_hdir != 0) begin
            held = (m_hdir > 0) ? up : dn;
            opp  = (m_hdir > 0) ? dn : up;
            if (!held || opp) m_hdir = 0;
            else begin
                m_t++;
                if (m_t == RD || (m_t > RD && (m_t - RD) % RP == 0))
                    m_bpm = sat(m_bpm + m_hdir);
            end
        end
    endtask

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negedge: drive, let one rising edge pass, compare at the next negedge.
    task automatic tick(bit up, bit dn, bit st);
        btn_up = up; btn_dn = dn; btn_st = st;
        @(posedge clk);
        model_step(up, dn, st);
        @(negedge clk);
        check("model_bpm", int'(bpm), m_bpm);
        check("model_running", int'(running), int'(m_run));
        check("model_beat", int'(beat), int'(m_beat));
        if (m_beat) check("model_idx", int'(beat_idx), m_idx);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; btn_up = 0; btn_dn = 0; btn_st = 0;
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit up, dn, st;
        int bpm;
        bit run, beat;
        int idx;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(bit u, bit d, bit s, int b, bit r, bit bt, int ix);
        vec_t v;
        v.up = u; v.dn = d; v.st = s; v.bpm = b; v.run = r; v.beat = bt; v.idx = ix;
        return v;
    endfunction

    initial begin
        bit u, d, s;
        int exp_bpm;

        vecs[0]  = mk(0, 0, 0, 120, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 121, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 121, 0, 0, 0);
        vecs[3]  = mk(0, 1, 0, 120, 0, 0, 0);
        vecs[4]  = mk(0, 0, 0, 120, 0, 0, 0);
        vecs[5]  = mk(1, 1, 0, 120, 0, 0, 0);
        vecs[6]  = mk(0, 0, 0, 120, 0, 0, 0);
        vecs[7]  = mk(1, 0, 0, 121, 0, 0, 0);
        vecs[8]  = mk(0, 0, 1, 121, 1, 0, 0);
        vecs[9]  = mk(0, 0, 1, 121, 1, 1, 0);
        vecs[10] = mk(0, 0, 0, 121, 1, 0, 0);
        vecs[11] = mk(0, 1, 0, 120, 1, 0, 0);
        vecs[12] = mk(0, 0, 0, 120, 1, 0, 0);

        do_reset();
        check("reset_bpm", int'(bpm), BPM_DEF);
        check("reset_running", int'(running), 0);
        check("reset_beat", int'(beat), 0);
        check("reset_idx", int'(beat_idx), 0);

        for (int i = 0; i < 13; i++) begin
            tick(vecs[i].up, vecs[i].dn, vecs[i].st);
            check($sformatf("vec%0d_bpm", i), int'(bpm), vecs[i].bpm);
            check($sformatf("vec%0d_running", i), int'(running), int'(vecs[i].run));
            check($sformatf("vec%0d_beat", i), int'(beat), int'(vecs[i].beat));
            if (vecs[i].beat) check($sformatf("vec%0d_idx", i), int'(beat_idx), vecs[i].idx);
        end

        // Start, downbeat, then a beat every 5 cycles at 120 BPM.
        do_reset();
        tick(0, 0, 0);
        tick(0, 0, 1);
        check("start_running", int'(running), 1);
        check("start_no_beat", int'(beat), 0);
        tick(0, 0, 0);
        check("downbeat", int'(beat), 1);
        check("downbeat_idx", int'(beat_idx), 0);
        for (int j = 1; j <= 20; j++) begin
            tick(0, 0, 0);
            check($sformatf("beat_at_%0d", j), int'(beat), int'(j % 5 == 0));
            if (j % 5 == 0) check($sformatf("idx_at_%0d", j), int'(beat_idx), (j / 5) % 4);
        end
        repeat (3) tick(0, 0, 0);
        tick(0, 0, 1);
        check("stop_running", int'(running), 0);
        check("stop_beat", int'(beat), 0);
        for (int j = 0; j < 12; j++) begin
            tick(0, 0, 0);
            check("stopped_beat", int'(beat), 0);
        end
        tick(0, 0, 1);
        check("restart_running", int'(running), 1);
        tick(0, 0, 0);
        check("restart_downbeat", int'(beat), 1);
        check("restart_idx", int'(beat_idx), 0);
        for (int j = 1; j <= 5; j++) begin
            tick(0, 0, 0);
            check($sformatf("restart_beat_%0d", j), int'(beat), int'(j == 5));
            if (j == 5) check("restart_idx1", int'(beat_idx), 1);
        end

        // Hold up: steps at press, +8, +12, +16, +20.
        do_reset();
        tick(0, 0, 0);
        for (int k = 0; k <= 20; k++) begin
            tick(1, 0, 0);
            exp_bpm = 121 + int'(k >= 8) + int'(k >= 12) + int'(k >= 16) + int'(k >= 20);
            check($sformatf("hold_k%0d", k), int'(bpm), exp_bpm);
        end
        tick(0, 0, 0);
        check("hold_release", int'(bpm), 125);
        for (int k = 0; k <= 8; k++) tick(1, 0, 0);
        check("rehold_delay_restarted", int'(bpm), 127);

        // Saturation at both bounds.
        repeat (600) tick(1, 0, 0);
        check("sat_max", int'(bpm), BPM_MAX);
        tick(0, 0, 0);
        tick(1, 0, 0);
        check("tap_at_max", int'(bpm), BPM_MAX);
        tick(0, 0, 0);
        repeat (1000) tick(0, 1, 0);
        check("sat_min", int'(bpm), BPM_MIN);
        tick(0, 0, 0);
        tick(0, 1, 0);
        check("tap_at_min", int'(bpm), BPM_MIN);
        tick(0, 0, 0);

        // Async reset mid-REPEAT while running, button kept held.
        do_reset();
        tick(0, 0, 0);
        tick(0, 0, 1);
        for (int k = 0; k < 14; k++) tick(1, 0, 0);
        check("pre_reset_bpm", int'(bpm), 123);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_bpm", int'(bpm), BPM_DEF);
        check("async_rst_running", int'(running), 0);
        check("async_rst_beat", int'(beat), 0);
        check("async_rst_idx", int'(beat_idx), 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) tick(1, 0, 0);
        check("held_after_reset", int'(bpm), BPM_DEF);
        tick(0, 0, 0);
        tick(1, 0, 0);
        check("repress_after_reset", int'(bpm), BPM_DEF + 1);
        tick(0, 0, 0);

        // Random button activity against the model.
        do_reset();
        u = 0; d = 0; s = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) u = !u;
            if ($urandom_range(15) == 0) d = !d;
            if ($urandom_range(29) == 0) s = !s;
            tick(u, d, s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tempo_ctrl.md
# tempo_ctrl

Central metronome controller: turns the cleaned up/down/start-stop button levels into a bounded BPM setting, run/stop state, and a beat-pulse schedule. Sits between the button conditioning stage and the beat outputs (LED/buzzer drivers and display). Beat timing uses a phase accumulator, so no divider is needed.

## Interface
- CLK_HZ, 50_000_000: clock frequency. Beat threshold THRESH = CLK_HZ*60.
- BPM_MIN, 30: lower BPM bound.
- BPM_MAX, 240: upper BPM bound.
- BPM_DEFAULT, 120: BPM after reset.
- REPEAT_DELAY, 25_000_000: cycles a held up/down button must stay high before auto-repeat starts.
- REPEAT_PERIOD, 5_000_000: cycles between auto-repeat steps.
- i_clk  in  1  single clock; all logic on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_btn_up  in  1  level; high while the up button is held (synchronized, debounced).
- i_btn_down  in  1  level; high while the down button is held.
- i_btn_start  in  1  level; each rising edge toggles run/stop.
- o_bpm  out  8  current BPM; reset value BPM_DEFAULT.
- o_running  out  1  high while the metronome runs; reset 0.
- o_beat  out  1  one-cycle beat pulse; reset 0.
- o_beat_idx  out  2  position in a 4-beat bar, valid with o_beat (0 = downbeat); reset 0.

## Operation
- Edge detection: one previous-sample register per button. A press is the cycle where the input is sampled 1 and the previous sample was 0.
- Up/down arbitration:
  - A press with the other button not held steps the BPM by ±1.
  - The result saturates at BPM_MIN/BPM_MAX and never wraps.
  - Up and down both held, or pressed on the same cycle: no step, and the hold FSM returns to IDLE.
- Hold FSM (shared, direction register dir):
  - IDLE -> DELAY on a valid press. The step is applied, dir is latched and the counter is cleared.
  - DELAY -> REPEAT when the counter reaches REPEAT_DELAY-1. A step is applied and the counter is cleared.
  - REPEAT: a step is applied each time the counter reaches REPEAT_PERIOD-1.
  - From any state -> IDLE when the dir button is released or the opposite button goes high.
- Run/stop:
  - A start press toggles o_running.
  - Start: clear the accumulator and beat index, and issue o_beat with idx 0 on the next cycle.
  - Stop: clear the accumulator and beat index. No o_beat while stopped.
  - The start button is independent of up/down; both can be acted on in the same cycle.
- Accumulator (while running, 33 bits, unsigned):
  - Each cycle: acc <= acc + o_bpm.
  - If acc + o_bpm >= THRESH: acc <= acc + o_bpm - THRESH, o_beat = 1, o_beat_idx increments mod 4.
  - A BPM change while running applies from the next add. The accumulator is not cleared.

## Timing
- A button rising edge sampled at edge N updates o_bpm / o_running at edge N; the new value is visible after that edge (1-cycle latency from the input).
- Start: o_running rises at edge N, the downbeat o_beat (idx 0) is asserted after edge N+1, and the first accumulated beat follows roughly THRESH/BPM cycles later.
- Beat interval = ceil or floor of THRESH/BPM cycles. The long-run average is exact.
- o_beat is never high on two consecutive cycles while BPM_MAX*2 < THRESH.
- Asynchronous reset mid-operation: every register returns to its reset value immediately. After deassertion a held button is not a press until it is released and pressed again, because the previous-sample registers reset to 1.

## Structure
- Shared package tempo_pkg holds:
  - BPM_W = 8 and BEATS_PER_BAR = 4
  - the hold-FSM state encoding (IDLE = 0, DELAY = 1, REPEAT = 2)
  - the ACC_W = 33 constant
- One sub-module, beat_accum: accumulator, threshold compare and beat index. Inputs are enable, clear and bpm; outputs are beat and idx.
- Top level holds the edge detection, arbitration, hold FSM and run/stop logic.

## Test plan
Parameters for all scenarios: CLK_HZ=10 (THRESH=600), REPEAT_DELAY=8, REPEAT_PERIOD=4, BPM_DEFAULT=120.
- Reset, then start press -> o_running=1; downbeat idx 0 on the next cycle; then beats every 5 cycles with idx 1, 2, 3, 0.
- Single up tap (1 cycle) -> o_bpm=121 with 1-cycle latency; no further steps.
- Up held for 20 cycles -> steps at the press, press+8, press+12, press+16 (+20 if still held); o_bpm=124 or 125. Release returns the FSM to IDLE.
- BPM_MAX-1, up held -> saturates at BPM_MAX. At BPM_MIN, down tap -> unchanged. Up and down pressed together -> no change.
- Running at 120, stop press -> o_beat stays 0; restart -> immediate downbeat with idx 0 and the accumulator cleared.
- Reset asserted mid-REPEAT while running -> all outputs at reset values; the still-held button causes no step after deassertion until it is re-pressed.
